// File: rtl/siso_pkg.sv
// Shared types, defaults and sizing helper for the SISO loop controller.
package siso_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Bits needed to hold values 0..max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/siso_loop_ctrl_if.sv
// Requester-side word interface of the SISO loop controller.
interface siso_loop_ctrl_if #(
    parameter int unsigned WIDTH = siso_pkg::DEF_WIDTH
);

    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             mismatch;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, busy, mismatch
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, busy, mismatch
    );

endinterface

// File: rtl/siso_loop_capture.sv
// Samples the chain's sout DEPTH+1 edges after each launched bit and
// reassembles the word MSB-first; runs independently of the sender FSM.
module siso_loop_capture import siso_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic             sout,
    output logic [WIDTH-1:0] rx_word,
    output logic             capture_done
);

    localparam int unsigned CW   = cnt_width(WIDTH + DEPTH + 1);
    localparam int unsigned LAST = DEPTH + WIDTH - 1;

    logic             active;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] rx_sh;
    logic [WIDTH-1:0] next_word_c;

    // Word as it would look after taking the current sout sample.
    assign next_word_c = {rx_sh, sout};

    // Cycle counter since launch; samples in window [DEPTH, DEPTH+WIDTH-1].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active       <= 1'b0;
            cnt          <= '0;
            rx_sh        <= '0;
            rx_word      <= '0;
            capture_done <= 1'b0;
        end else begin
            capture_done <= 1'b0;
            if (launch) begin
                active <= 1'b1;
                cnt    <= '0;
            end else if (active) begin
                cnt <= cnt + CW'(1);
                if (cnt >= CW'(DEPTH)) begin
                    rx_sh <= next_word_c[WIDTH-2:0];
                end
                if (cnt == CW'(LAST)) begin
                    active       <= 1'b0;
                    rx_word      <= next_word_c;
                    capture_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/siso_loop_ctrl.sv
// Sequencer for an external free-running SISO chain: serialises an accepted
// word MSB-first onto sin and returns the looped-back word with a valid pulse.
// Optional macro SISO_LOOP_CHECK_EN adds a retained-word compare (mismatch).
module siso_loop_ctrl import siso_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    siso_loop_ctrl_if.slave  bus,
    output logic             sin,
    input  logic             sout
);

    localparam int unsigned CW = cnt_width(WIDTH + DEPTH + 1);

    state_t           state;
    logic [WIDTH-2:0] tx_sh;
    logic [CW-1:0]    tx_cnt;
    logic             tx_ready_q;
    logic             rx_valid_q;
    logic             busy_q;
    logic             accept_c;
    logic [WIDTH-1:0] rx_word;
    logic             capture_done;

    // Handshake completes only while IDLE holds tx_ready.
    assign accept_c = bus.tx_valid & tx_ready_q;

    siso_loop_capture #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_capture (
        .clk          (clk),
        .rst          (rst),
        .launch       (accept_c),
        .sout         (sout),
        .rx_word      (rx_word),
        .capture_done (capture_done)
    );

    // Sender FSM with registered handshake, status and serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sin        <= 1'b0;
            tx_sh      <= '0;
            tx_cnt     <= '0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    sin <= 1'b0;
                    if (accept_c) begin
                        tx_sh      <= bus.tx_data[WIDTH-2:0];
                        sin        <= bus.tx_data[WIDTH-1];
                        tx_cnt     <= '0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tx_cnt == CW'(WIDTH - 1)) begin
                        sin   <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                        sin    <= tx_sh[WIDTH-2];
                        tx_sh  <= tx_sh << 1;
                    end
                end
                DRAIN: begin
                    sin <= 1'b0;
                    if (capture_done) begin
                        rx_valid_q <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    tx_cnt     <= '0;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_word;
    assign bus.busy     = busy_q;

`ifdef SISO_LOOP_CHECK_EN
    logic [WIDTH-1:0] ref_word;
    logic             mismatch_q;

    // Retain the sent word; compare on entry to DONE, sticky until next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_word   <= '0;
            mismatch_q <= 1'b0;
        end else if (accept_c) begin
            ref_word   <= bus.tx_data;
            mismatch_q <= 1'b0;
        end else if ((state == DRAIN) && capture_done) begin
            mismatch_q <= (rx_word != ref_word);
        end
    end

    assign bus.mismatch = mismatch_q;
`else
    assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_siso_loop_ctrl.sv
// Directed bench for siso_loop_ctrl (8x4 instance plus a 2x1 corner instance).
module tb_siso_loop_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned SD = 1;

`ifdef SISO_LOOP_CHECK_EN
    localparam logic MM_EN = 1'b1;
`else
    localparam logic MM_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         sin;
    logic         sout;
    logic [D-1:0] chain;
    logic         invert;
    logic         s_sin;
    logic         s_sout;
    logic [SD-1:0] s_chain;

    int checks;
    int errors;

    siso_loop_ctrl_if #(.WIDTH(W))  bus ();
    siso_loop_ctrl_if #(.WIDTH(SW)) sbus ();

    siso_loop_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sin  (sin),
        .sout (sout)
    );

    siso_loop_ctrl #(.WIDTH(SW), .DEPTH(SD)) dut_small (
        .clk  (clk),
        .rst  (rst),
        .bus  (sbus),
        .sin  (s_sin),
        .sout (s_sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External free-running chains (optional inverter on the main one).
    always @(posedge clk) chain   <= {chain[D-2:0], sin};
    always @(posedge clk) s_chain <= s_sin;
    assign sout   = chain[D-1] ^ invert;
    assign s_sout = s_chain[SD-1];

    // Present a word at a negedge with tx_ready high; returns at the negedge after the accept edge.
    task automatic launch(input logic [W-1:0] w);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Bounded wait for rx_valid; n is negedges elapsed since the accept edge, -1 on timeout.
    task automatic wait_rx(input int limit, output int n, output logic [W-1:0] d, output logic mm);
        n  = -1;
        d  = '0;
        mm = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) begin
                n  = i;
                d  = bus.rx_data;
                mm = bus.mismatch;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        sbus.tx_valid = 1'b0;
        sbus.tx_data  = '0;
        invert        = 1'b0;
        chain         = '0;
        s_chain       = '0;
        rst           = 1'b1;
        #2 rst        = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", bus.tx_ready); end
        checks++; if (sin !== 1'b0) begin errors++; $display("FAIL reset_sin got %b want 0", sin); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
        checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", bus.mismatch); end
    endtask

    task automatic test_loopback();
        logic [W-1:0] word;
        word = 8'hA5;
        launch(word);
        checks++; if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL lb_accept_status got ready=%b busy=%b want ready=0 busy=1", bus.tx_ready, bus.busy); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (sin !== word[7-k]) begin errors++; $display("FAIL lb_sin_bit%0d got %b want %b", k, sin, word[7-k]); end
        end
        for (int k = 8; k <= 13; k++) begin
            @(negedge clk);
            if (k == 8) begin
                checks++; if (sin !== 1'b0) begin errors++; $display("FAIL lb_sin_drain got %b want 0", sin); end
            end
            checks++; if (bus.rx_valid !== (k == 13)) begin errors++; $display("FAIL lb_rx_valid_t%0d got %b want %b", k, bus.rx_valid, (k == 13)); end
        end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL lb_rx_data got %h want a5", bus.rx_data); end
        checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL lb_mismatch got %b want 0", bus.mismatch); end
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL lb_ready_in_done got %b want 0", bus.tx_ready); end
        @(negedge clk);
        checks++; if (bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL lb_return_idle got valid=%b ready=%b busy=%b want 0 1 0", bus.rx_valid, bus.tx_ready, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int rx1_n, rx2_n, ready_n, drop_n;
        logic [W-1:0] d1, d2;
        rx1_n = -1; rx2_n = -1; ready_n = -1; drop_n = -1;
        d1 = '0; d2 = '0;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'hC3;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_first_accept got busy=%b want 1", bus.busy); end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) begin
                if (rx1_n < 0) begin rx1_n = n; d1 = bus.rx_data; end
                else if (rx2_n < 0) begin rx2_n = n; d2 = bus.rx_data; end
            end
            if (n == drop_n) bus.tx_valid = 1'b0;
            if (bus.tx_ready === 1'b1 && ready_n < 0) begin ready_n = n; drop_n = n + 1; end
            if (rx2_n > 0) break;
        end
        bus.tx_valid = 1'b0;
        checks++; if (rx1_n != 13) begin errors++; $display("FAIL b2b_rx1_cycle got %0d want 13", rx1_n); end
        checks++; if (d1 !== 8'h3C) begin errors++; $display("FAIL b2b_rx1_data got %h want 3c", d1); end
        checks++; if (ready_n != 14) begin errors++; $display("FAIL b2b_ready_cycle got %0d want 14", ready_n); end
        checks++; if (rx2_n != 28) begin errors++; $display("FAIL b2b_rx2_cycle got %0d want 28", rx2_n); end
        checks++; if (d2 !== 8'hC3) begin errors++; $display("FAIL b2b_rx2_data got %h want c3", d2); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int cnt, rx_n;
        logic [W-1:0] d;
        cnt = 0; rx_n = -1; d = '0;
        launch(8'h01);
        @(negedge clk);
        @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL busy_tx_ready got %b want 0", bus.tx_ready); end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        for (int n = 4; n <= 30; n++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) begin cnt++; rx_n = n; d = bus.rx_data; end
        end
        checks++; if (cnt != 1) begin errors++; $display("FAIL busy_rx_count got %0d want 1", cnt); end
        checks++; if (rx_n != 13 || d !== 8'h01) begin errors++; $display("FAIL busy_rx_word got n=%0d data=%h want n=13 data=01", rx_n, d); end
        checks++; if (bus.busy !== 1'b0 || bus.tx_ready !== 1'b1) begin errors++; $display("FAIL busy_end_idle got busy=%b ready=%b want 0 1", bus.busy, bus.tx_ready); end
    endtask

    task automatic test_mid_reset();
        int seen, n;
        logic [W-1:0] d;
        logic mm;
        seen = 0;
        launch(8'h96);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (sin !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_abort got sin=%b busy=%b want 0 0", sin, bus.busy); end
        checks++; if (bus.tx_ready !== 1'b1 || bus.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_values got ready=%b rx_data=%h want 1 00", bus.tx_ready, bus.rx_data); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_rx_valid got %0d pulses want 0", seen); end
        launch(8'h5A);
        wait_rx(40, n, d, mm);
        checks++; if (n != 13 || d !== 8'h5A) begin errors++; $display("FAIL midrst_recover got n=%0d data=%h want n=13 data=5a", n, d); end
        @(negedge clk);
    endtask

    task automatic test_fault();
        int n;
        logic [W-1:0] d;
        logic mm;
        invert = 1'b1;
        launch(8'h0F);
        wait_rx(40, n, d, mm);
        checks++; if (n != 13 || d !== 8'hF0) begin errors++; $display("FAIL fault_rx got n=%0d data=%h want n=13 data=f0", n, d); end
        checks++; if (mm !== MM_EN) begin errors++; $display("FAIL fault_mismatch got %b want %b", mm, MM_EN); end
        repeat (3) @(negedge clk);
        checks++; if (bus.mismatch !== MM_EN) begin errors++; $display("FAIL fault_mismatch_sticky got %b want %b", bus.mismatch, MM_EN); end
        invert = 1'b0;
        launch(8'h0F);
        checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL fault_mismatch_clear got %b want 0", bus.mismatch); end
        wait_rx(40, n, d, mm);
        checks++; if (d !== 8'h0F || mm !== 1'b0) begin errors++; $display("FAIL fault_clean_rx got data=%h mm=%b want 0f 0", d, mm); end
        @(negedge clk);
    endtask

    task automatic test_small_config();
        logic [SW-1:0] words [2];
        words[0] = 2'b10;
        words[1] = 2'b01;
        for (int w = 0; w < 2; w++) begin
            int rx_n;
            logic [SW-1:0] d;
            rx_n = -1; d = '0;
            sbus.tx_data  = words[w];
            sbus.tx_valid = 1'b1;
            @(negedge clk);
            sbus.tx_valid = 1'b0;
            checks++; if (s_sin !== words[w][1]) begin errors++; $display("FAIL small_sin_msb_w%0d got %b want %b", w, s_sin, words[w][1]); end
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    checks++; if (s_sin !== words[w][0]) begin errors++; $display("FAIL small_sin_lsb_w%0d got %b want %b", w, s_sin, words[w][0]); end
                end
                if (sbus.rx_valid === 1'b1 && rx_n < 0) begin rx_n = n; d = sbus.rx_data; end
            end
            checks++; if (rx_n != 4 || d !== words[w]) begin errors++; $display("FAIL small_rx_w%0d got n=%0d data=%b want n=4 data=%b", w, rx_n, d, words[w]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_fault();
        test_small_config();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/siso_loop_ctrl.md
Name: siso_loop_ctrl

Overview:
- Sequencer for a free-running SISO shift register chain (DEPTH flops, shifts every clk, ports sin/sout).
- Accepts a parallel word over valid/ready and launches it MSB-first on the chain's sin.
- Samples the chain's sout with the correct latency, reassembles the word and returns it with a one-cycle valid pulse.
- Used as loopback/BIST driver and as the single owner of the chain's sin.

Parameters:
- WIDTH, 8, bits per transferred word (>=2).
- DEPTH, 4, flop count of the external SISO chain (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- tx_valid  in  1  tx_data holds a word to send
- tx_ready  out  1  controller can accept a word (high only in IDLE)
- tx_data  in  WIDTH  word to serialise
- sin  out  WIDTH=1  serial bit to the chain's sin input (registered)
- sout  in  1  serial bit from the chain's sout output
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_data  out  WIDTH  reassembled word, held until next rx_valid
- busy  out  1  high in any state other than IDLE
- mismatch  out  1  see Optional Feature

Behaviour:
- Reset (rst=0, async): state=IDLE, sin=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0, mismatch=0, counters=0.
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - tx_ready=1, sin=0.
  - On an edge with tx_valid&tx_ready: latch tx_data into a shift register, drive sin=tx_data[WIDTH-1] from that edge, set cnt=0, go to SHIFT.
- SHIFT:
  - On each edge, cnt increments and sin takes the next lower bit.
  - The bit launched with cnt=k is tx_data[WIDTH-1-k].
  - After bit 0 has been on sin for one cycle: sin returns to 0, go to DRAIN.
- Capture timing:
  - A bit launched on sin at edge E is sampled from sout at edge E+DEPTH+1.
  - Sampling shifts left into the rx shift register (first sampled bit ends at MSB).
  - Capture runs across the SHIFT/DRAIN boundary independent of state; a separate capture counter counts WIDTH samples.
- DRAIN:
  - sin=0, waiting for remaining samples.
  - When the WIDTH-th sample is taken: rx_data updates on that edge, go to DONE.
- DONE:
  - rx_valid=1 for exactly this one cycle.
  - Next edge returns to IDLE (tx_ready=1 one cycle after rx_valid).
- Cycle counts:
  - Accept edge to rx_valid high: WIDTH+DEPTH+1 edges.
  - Minimum word-to-word period: WIDTH+DEPTH+3 cycles.
- Boundary conditions:
  - tx_valid while busy is ignored; the word is not lost from the requester's side because tx_ready=0.
  - tx_data changes after acceptance have no effect.
  - rst asserted mid-transfer: immediate abort to reset values, partial rx discarded, no rx_valid.
  - DEPTH=1 and WIDTH=2 must work (capture starts before SHIFT ends).
  - Counter widths are sized for WIDTH+DEPTH+1 with no wrap.

Optional Feature:
- Macro SISO_LOOP_CHECK_EN.
- When defined:
  - The accepted word is retained.
  - In DONE, mismatch is set to 1 if rx_data != retained word, else 0.
  - mismatch is sticky until the next accepted word or reset.
- When undefined:
  - mismatch is tied to 0.
  - No retained-word register is generated.

Decomposition:
- Shared package siso_pkg holds:
  - state enum (IDLE/SHIFT/DRAIN/DONE, 2-bit encoding 00/01/10/11);
  - default WIDTH/DEPTH constants;
  - a clog2-based counter width function.
- One sub-module, siso_loop_capture, handles the sout sampling counter and the rx shift register. It is enabled by a launch strobe and emits capture_done.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release. Required: tx_ready=1, sin=0, busy=0, rx_data=0, no rx_valid.
- Loopback with WIDTH=8, DEPTH=4, tx_data=8'hA5 accepted at edge T:
  - sin sequence is 1,0,1,0,0,1,0,1 on edges T..T+7;
  - rx_valid pulses after edge T+13;
  - rx_data=8'hA5;
  - mismatch=0 (SISO_LOOP_CHECK_EN defined).
- Back-to-back: tx_valid held high with 8'h3C then 8'hC3.
  - Second accept occurs exactly one cycle after the first rx_valid.
  - Outputs are 8'h3C then 8'hC3.
- Busy ignore: pulse tx_valid with 8'hFF during SHIFT of 8'h01. Required: tx_ready=0, output 8'h01 only, exactly one rx_valid.
- Mid-transfer reset: assert rst=0 three cycles into SHIFT.
  - Required: sin=0, busy=0, rx_valid never pulses.
  - After release, 8'h5A transfers correctly.
- Fault check: insert an inverter between the chain's sout and the controller, send 8'h0F. Required: rx_data=8'hF0, mismatch=1 held until the next accept.
